// File: rtl/sphere_scan.sv
// rtl/sphere_scan.sv - sequential multi-sphere ray intersection unit; optional SPHERE_SCAN_ORIGIN_EN adds ray_origin

package sphere_scan_pkg;
    // Q8.8 signed fixed point; vectors pack {z, y, x} with x in the low bits
    localparam int FP_W  = 16;
    localparam int FRAC  = 8;
    localparam int VEC_W = 3 * FP_W;

    typedef logic signed [FP_W-1:0] fixed_point_t;
    typedef logic [VEC_W-1:0]       vector_t;
    typedef logic signed [39:0]     wide_t;
    typedef logic [FP_W:0]          fp_res_t;   // {overflow, value}

    localparam wide_t FP_MAX = 40'sd32767;
    localparam wide_t FP_MIN = -40'sd32768;

    function automatic fp_res_t fp_sat(input wide_t x);
        if (x > FP_MAX) return {1'b1, 1'b0, {(FP_W-1){1'b1}}};
        if (x < FP_MIN) return {1'b1, 1'b1, {(FP_W-1){1'b0}}};
        return {1'b0, x[FP_W-1:0]};
    endfunction

    function automatic fixed_point_t vec_get(input vector_t v, input int k);
        return fixed_point_t'(v[k*FP_W +: FP_W]);
    endfunction

    function automatic fp_res_t fp_sub(input fixed_point_t a, input fixed_point_t b);
        return fp_sat(wide_t'(a) - wide_t'(b));
    endfunction

    function automatic fp_res_t fp_neg(input fixed_point_t a);
        return fp_sat(-wide_t'(a));
    endfunction

    function automatic fp_res_t fp_mul(input fixed_point_t a, input fixed_point_t b);
        return fp_sat((wide_t'(a) * wide_t'(b)) >>> FRAC);
    endfunction

    // Dot product keeps full precision through the sum and saturates once
    function automatic fp_res_t fp_dot(input vector_t u, input vector_t v);
        wide_t acc;
        acc = '0;
        for (int k = 0; k < 3; k++) begin
            acc = acc + wide_t'(vec_get(u, k)) * wide_t'(vec_get(v, k));
        end
        return fp_sat(acc >>> FRAC);
    endfunction

    // Component-wise saturating u - v; top bit is the OR of the lane overflows
    function automatic logic [VEC_W:0] fp_vsub(input vector_t u, input vector_t v);
        logic [VEC_W:0] res;
        fp_res_t        t;
        res = '0;
        for (int k = 0; k < 3; k++) begin
            t = fp_sub(vec_get(u, k), vec_get(v, k));
            res[k*FP_W +: FP_W] = t[FP_W-1:0];
            res[VEC_W] = res[VEC_W] | t[FP_W];
        end
        return res;
    endfunction

    // disc = b*b - (m - rr); returns {overflow, disc < 0}
    function automatic logic [1:0] fp_disc(input fixed_point_t b, input fixed_point_t m,
                                           input fixed_point_t rr);
        fp_res_t bb;
        fp_res_t mr;
        wide_t   d;
        bb = fp_mul(b, b);
        mr = fp_sub(m, rr);
        d  = wide_t'(fixed_point_t'(bb[FP_W-1:0])) - wide_t'(fixed_point_t'(mr[FP_W-1:0]));
        return {bb[FP_W] | mr[FP_W] | (d > FP_MAX) | (d < FP_MIN), d < 0};
    endfunction
endpackage

module sphere_scan
    import sphere_scan_pkg::*;
#(
    parameter int NUM_SPHERES = 8,
    parameter int IDX_W       = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [VEC_W-1:0]   wr_center,
    input  logic [FP_W-1:0]    wr_radius,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic               ray_valid,
    output logic               ray_ready,
    input  logic [VEC_W-1:0]   ray,
`ifdef SPHERE_SCAN_ORIGIN_EN
    input  logic [VEC_W-1:0]   ray_origin,
`endif
    output logic               res_valid,
    input  logic               res_ready,
    output logic               hit_any,
    output logic [IDX_W-1:0]   hit_idx,
    output logic [FP_W-1:0]    hit_tca,
    output logic [NUM_SPHERES-1:0] hit_mask,
    output logic               ovf_any
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_issue;
    logic                w_last;
    logic [IDX_W-1:0]    r_cnt;
    logic                r_drain;

    vector_t             r_ray;
    vector_t             w_orig;
    vector_t             r_cen [NUM_SPHERES];
    fixed_point_t        r_rad [NUM_SPHERES];
    logic [NUM_SPHERES-1:0] r_vld;

    // stage 1 datapath
    logic [VEC_W:0]      w_ocr;
    vector_t             w_oc;
    fp_res_t             w_b;
    fp_res_t             w_m;
    fp_res_t             w_rr;
    fp_res_t             w_tca;

    logic                r_s1_vld;
    logic                r_s1_ent;
    logic [IDX_W-1:0]    r_s1_idx;
    fixed_point_t        r_s1_b;
    fixed_point_t        r_s1_m;
    fixed_point_t        r_s1_rr;
    fixed_point_t        r_s1_tca;
    logic                r_s1_ovf;

    // stage 2 datapath
    logic [1:0]          w_disc;
    logic                r_s2_vld;
    logic                r_s2_ent;
    logic [IDX_W-1:0]    r_s2_idx;
    fixed_point_t        r_s2_tca;
    logic                r_s2_neg;
    logic                r_s2_ovf;

    // accumulator
    logic                w_hit;
    logic                w_better;
    logic                r_hit_any;
    logic [IDX_W-1:0]    r_hit_idx;
    fixed_point_t        r_hit_tca;
    logic [NUM_SPHERES-1:0] r_mask;
    logic                r_ovf_any;

    assign w_last    = (r_cnt == IDX_W'(NUM_SPHERES - 1));
    assign ray_ready = (r_state == ST_IDLE);
    assign wr_ready  = (r_state == ST_IDLE);
    assign res_valid = (r_state == ST_DONE);
    assign hit_any   = r_hit_any;
    assign hit_idx   = r_hit_idx;
    assign hit_tca   = r_hit_tca;
    assign hit_mask  = r_mask;
    assign ovf_any   = r_ovf_any;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // FSM next state and per-cycle strobes
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_issue  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ray_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_issue = 1'b1;
                if (w_last) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_drain) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Sphere table; writes only land while idle so a scan sees a frozen table
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else if (wr_en && (r_state == ST_IDLE)) begin
            r_vld[wr_idx] <= wr_valid;
            r_cen[wr_idx] <= wr_center;
            r_rad[wr_idx] <= wr_radius;
        end
    end

    // Ray latch, scan index and drain counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_drain <= 1'b0;
            r_ray   <= '0;
        end else begin
            if (w_accept) begin
                r_ray <= ray;
                r_cnt <= '0;
            end else if (w_issue) begin
                r_cnt <= r_cnt + IDX_W'(1);
            end
            r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
        end
    end

`ifdef SPHERE_SCAN_ORIGIN_EN
    vector_t r_orig;

    // Origin is captured together with the direction
    always_ff @(posedge clk) begin
        if (rst)           r_orig <= '0;
        else if (w_accept) r_orig <= ray_origin;
    end

    assign w_orig = r_orig;
`else
    assign w_orig = '0;
`endif

    assign w_ocr = fp_vsub(w_orig, r_cen[r_cnt]);
    assign w_oc  = w_ocr[VEC_W-1:0];
    assign w_b   = fp_dot(r_ray, w_oc);
    assign w_m   = fp_dot(w_oc, w_oc);
    assign w_rr  = fp_mul(r_rad[r_cnt], r_rad[r_cnt]);
    assign w_tca = fp_neg(w_b[FP_W-1:0]);

    // Stage 1: projection, squared distance and squared radius of the issued entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_issue;
            if (w_issue) begin
                r_s1_ent <= r_vld[r_cnt];
                r_s1_idx <= r_cnt;
                r_s1_b   <= w_b[FP_W-1:0];
                r_s1_m   <= w_m[FP_W-1:0];
                r_s1_rr  <= w_rr[FP_W-1:0];
                r_s1_tca <= w_tca[FP_W-1:0];
                r_s1_ovf <= w_ocr[VEC_W] | w_b[FP_W] | w_m[FP_W] | w_rr[FP_W] | w_tca[FP_W];
            end
        end
    end

    assign w_disc = fp_disc(r_s1_b, r_s1_m, r_s1_rr);

    // Stage 2: discriminant sign and accumulated overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_ent <= r_s1_ent;
                r_s2_idx <= r_s1_idx;
                r_s2_tca <= r_s1_tca;
                r_s2_neg <= w_disc[0];
                r_s2_ovf <= r_s1_ovf | w_disc[1];
            end
        end
    end

    assign w_hit    = r_s2_ent & ~r_s2_neg & ~r_s2_ovf;
    // strict less-than keeps the lowest index on equal tca
    assign w_better = w_hit & ~r_s2_tca[FP_W-1] & (~r_hit_any | (r_s2_tca < r_hit_tca));

    // Result accumulator, cleared when a new ray is accepted
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_hit_any <= 1'b0;
            r_hit_idx <= '0;
            r_hit_tca <= '0;
            r_mask    <= '0;
            r_ovf_any <= 1'b0;
        end else if (r_s2_vld) begin
            r_mask[r_s2_idx] <= w_hit;
            r_ovf_any        <= r_ovf_any | (r_s2_ent & r_s2_ovf);
            if (w_better) begin
                r_hit_any <= 1'b1;
                r_hit_idx <= r_s2_idx;
                r_hit_tca <= r_s2_tca;
            end
        end
    end

endmodule

// File: tb/tb_sphere_scan.sv
// tb/tb_sphere_scan.sv - self-checking bench for sphere_scan with an exact-arithmetic reference model

module tb_sphere_scan;
    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [47:0] wr_center;
    logic [15:0] wr_radius;
    logic        wr_valid;
    logic        wr_ready;
    logic        ray_valid;
    logic        ray_ready;
    logic [47:0] ray;
`ifdef SPHERE_SCAN_ORIGIN_EN
    logic [47:0] ray_origin;
`endif
    logic        res_valid;
    logic        res_ready;
    logic        hit_any;
    logic [2:0]  hit_idx;
    logic [15:0] hit_tca;
    logic [7:0]  hit_mask;
    logic        ovf_any;

    always #5 clk = ~clk;

    sphere_scan #(.NUM_SPHERES(N), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_center(wr_center), .wr_radius(wr_radius),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .ray(ray),
`ifdef SPHERE_SCAN_ORIGIN_EN
        .ray_origin(ray_origin),
`endif
        .res_valid(res_valid), .res_ready(res_ready),
        .hit_any(hit_any), .hit_idx(hit_idx), .hit_tca(hit_tca),
        .hit_mask(hit_mask), .ovf_any(ovf_any)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference table and ray, raw Q8.8 integers
    int m_c [N][3];
    int m_r [N];
    bit m_v [N];
    int m_l [3];
    int m_o [3];

    // expected results
    bit     e_any;
    longint e_idx;
    longint e_tca;
    longint e_mask;
    bit     e_ovf;

    // optional constant expectations for directed cases
    bit     d_en = 0;
    bit     d_any;
    longint d_idx, d_tca, d_mask;
    bit     d_ovf;

    // pending write issued in the same cycle as the ray accept
    int pw_idx, pw_r;
    int pw_c [3];
    bit pw_v;

    task automatic chk_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] pack3(input int x, input int y, input int z);
        return {16'(z), 16'(y), 16'(x)};
    endfunction

    function automatic bit oor(input longint x);
        return (x > 32767) || (x < -32768);
    endfunction

    // Exact integer evaluation; any out-of-range quantity marks overflow
    function automatic void model_entry(input int i, output bit hit, output bit ovf,
                                        output longint tca);
        longint oc [3];
        longint b, m, rr, bb, mr, d;
        ovf = 0;
        for (int k = 0; k < 3; k++) begin
            oc[k] = longint'(m_o[k]) - longint'(m_c[i][k]);
            ovf |= oor(oc[k]);
        end
        b  = (longint'(m_l[0]) * oc[0] + longint'(m_l[1]) * oc[1] + longint'(m_l[2]) * oc[2]) >>> 8;
        m  = (oc[0] * oc[0] + oc[1] * oc[1] + oc[2] * oc[2]) >>> 8;
        rr = (longint'(m_r[i]) * longint'(m_r[i])) >>> 8;
        tca = -b;
        bb = (b * b) >>> 8;
        mr = m - rr;
        d  = bb - mr;
        ovf |= oor(b) | oor(m) | oor(rr) | oor(tca) | oor(bb) | oor(mr) | oor(d);
        hit = m_v[i] && !ovf && (d >= 0);
    endfunction

    function automatic void model_scan();
        bit hit, ovf;
        longint tca;
        e_any = 0; e_idx = 0; e_tca = 0; e_mask = 0; e_ovf = 0;
        for (int i = 0; i < N; i++) begin
            model_entry(i, hit, ovf, tca);
            if (hit) e_mask |= (longint'(1) << i);
            if (m_v[i] && ovf) e_ovf = 1;
            if (hit && tca >= 0 && (!e_any || tca < e_tca)) begin
                e_any = 1; e_idx = i; e_tca = tca;
            end
        end
    endfunction

    task automatic expect_direct(input bit a, input int idx, input int tca, input int mask, input bit o);
        d_en = 1; d_any = a; d_idx = idx; d_tca = tca; d_mask = mask; d_ovf = o;
    endtask

    task automatic check_outputs(input string tag);
        chk_eq({tag, "_res_valid"}, res_valid, 1);
        chk_eq({tag, "_hit_any"}, hit_any, e_any);
        chk_eq({tag, "_hit_idx"}, hit_idx, e_idx);
        chk_eq({tag, "_hit_tca"}, hit_tca, e_tca);
        chk_eq({tag, "_hit_mask"}, hit_mask, e_mask);
        chk_eq({tag, "_ovf_any"}, ovf_any, e_ovf);
        chk_eq({tag, "_ray_ready"}, ray_ready, 0);
        chk_eq({tag, "_wr_ready"}, wr_ready, 0);
        if (d_en) begin
            chk_eq({tag, "_spec_any"}, hit_any, d_any);
            chk_eq({tag, "_spec_idx"}, hit_idx, d_idx);
            chk_eq({tag, "_spec_tca"}, hit_tca, d_tca);
            chk_eq({tag, "_spec_mask"}, hit_mask, d_mask);
            chk_eq({tag, "_spec_ovf"}, ovf_any, d_ovf);
        end
    endtask

    task automatic drive_junk(input bit junk);
        wr_en = junk;
        if (junk) begin
            wr_idx    = 3'($urandom);
            wr_center = {16'($urandom), 32'($urandom)};
            wr_radius = 16'($urandom);
            wr_valid  = 1'b1;
        end
    endtask

    task automatic do_write(input int idx, input int cx, input int cy, input int cz,
                            input int r, input bit v);
        @(negedge clk);
        chk_eq("wr_ready_idle", wr_ready, 1);
        wr_en = 1; wr_idx = 3'(idx); wr_center = pack3(cx, cy, cz);
        wr_radius = 16'(r); wr_valid = v;
        @(posedge clk); #1;
        wr_en = 0;
        m_c[idx] = '{cx, cy, cz}; m_r[idx] = r; m_v[idx] = v;
    endtask

    task automatic clear_table();
        for (int i = 0; i < N; i++) do_write(i, 0, 0, 0, 0, 0);
    endtask

    task automatic run_ray(input string tag, input int lx, input int ly, input int lz,
                           input int ox, input int oy, input int oz,
                           input int hold, input bit junk, input bit co_wr);
        int lat;
        bit seen;
        @(negedge clk);
        m_l = '{lx, ly, lz};
        ray = pack3(lx, ly, lz);
`ifdef SPHERE_SCAN_ORIGIN_EN
        ray_origin = pack3(ox, oy, oz);
        m_o = '{ox, oy, oz};
`else
        m_o = '{0, 0, 0};
        if (ox + oy + oz != 0) $display("note: origin ignored in this build");
`endif
        ray_valid = 1;
        if (co_wr) begin
            wr_en = 1; wr_idx = 3'(pw_idx); wr_center = pack3(pw_c[0], pw_c[1], pw_c[2]);
            wr_radius = 16'(pw_r); wr_valid = pw_v;
        end
        chk_eq({tag, "_ray_ready_idle"}, ray_ready, 1);
        @(posedge clk); #1;
        ray_valid = 0;
        wr_en = 0;
        if (co_wr) begin
            m_c[pw_idx] = pw_c; m_r[pw_idx] = pw_r; m_v[pw_idx] = pw_v;
        end
        model_scan();
        lat = 1; seen = 0;
        while (!seen && lat <= 40) begin
            @(negedge clk);
            if (res_valid) seen = 1;
            else begin
                drive_junk(junk);
                @(posedge clk);
                lat++;
            end
        end
        wr_en = 0;
        chk_eq({tag, "_latency"}, lat, N + 3);
        check_outputs(tag);
        for (int h = 0; h < hold; h++) begin
            drive_junk(junk);
            @(posedge clk);
            @(negedge clk);
            check_outputs({tag, "_hold"});
        end
        wr_en = 0;
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        @(negedge clk);
        chk_eq({tag, "_res_valid_after"}, res_valid, 0);
        chk_eq({tag, "_ray_ready_after"}, ray_ready, 1);
        d_en = 0;
    endtask

    function automatic int rand_comp();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 3072)) - 1536;
    endfunction

    function automatic int rand_dir();
        return int'($urandom_range(0, 512)) - 256;
    endfunction

    initial begin
        rst = 1; wr_en = 0; wr_idx = 0; wr_center = 0; wr_radius = 0; wr_valid = 0;
        ray_valid = 0; ray = 0; res_ready = 0;
`ifdef SPHERE_SCAN_ORIGIN_EN
        ray_origin = 0;
`endif
        for (int i = 0; i < N; i++) begin
            m_c[i] = '{0, 0, 0}; m_r[i] = 0; m_v[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk_eq("rst_ray_ready", ray_ready, 1);
        chk_eq("rst_wr_ready", wr_ready, 1);
        chk_eq("rst_res_valid", res_valid, 0);
        chk_eq("rst_hit_any", hit_any, 0);
        chk_eq("rst_hit_idx", hit_idx, 0);
        chk_eq("rst_hit_tca", hit_tca, 0);
        chk_eq("rst_hit_mask", hit_mask, 0);
        chk_eq("rst_ovf_any", ovf_any, 0);

        // single sphere straight ahead at z=5
        do_write(0, 0, 0, 1280, 256, 1);
        expect_direct(1, 0, 1280, 8'h01, 0);
        run_ray("single", 0, 0, 256, 0, 0, 0, 0, 0, 0);

        // nearest of several, one off-axis miss
        clear_table();
        do_write(2, 0, 0, 2304, 256, 1);
        do_write(5, 0, 0, 1024, 256, 1);
        do_write(6, 768, 0, 1024, 256, 1);
        expect_direct(1, 5, 1024, 8'h24, 0);
        run_ray("nearest", 0, 0, 256, 0, 0, 0, 0, 0, 0);

        // equal tca keeps the lower index, then the survivor after deletion
        clear_table();
        do_write(1, 0, 0, 1536, 512, 1);
        do_write(3, 0, 0, 1536, 512, 1);
        expect_direct(1, 1, 1536, 8'h0a, 0);
        run_ray("tie", 0, 0, 256, 0, 0, 0, 0, 0, 0);
        do_write(1, 0, 0, 1536, 512, 0);
        expect_direct(1, 3, 1536, 8'h08, 0);
        run_ray("tie_del", 0, 0, 256, 0, 0, 0, 0, 0, 0);

        // sphere fully behind, and origin inside a sphere whose center lies behind
        clear_table();
        do_write(0, 0, 0, -1280, 256, 1);
        do_write(4, 0, 0, -128, 512, 1);
        expect_direct(0, 0, 0, 8'h11, 0);
        run_ray("behind", 0, 0, 256, 0, 0, 0, 0, 0, 0);

        // stalled result with writes attempted during scan and DONE, then readback
        clear_table();
        do_write(0, 0, 0, 1280, 256, 1);
        expect_direct(1, 0, 1280, 8'h01, 0);
        run_ray("stall", 0, 0, 256, 0, 0, 0, 10, 1, 0);
        expect_direct(1, 0, 1280, 8'h01, 0);
        run_ray("readback", 0, 0, 256, 0, 0, 0, 0, 0, 0);

        // write landing in the accept cycle is seen by that scan
        pw_idx = 0; pw_c = '{0, 0, 1280}; pw_r = 256; pw_v = 0;
        expect_direct(0, 0, 0, 8'h00, 0);
        run_ray("co_write", 0, 0, 256, 0, 0, 0, 0, 0, 1);

        // overflowing entry next to a normal one
        clear_table();
        do_write(0, 0, 0, 1280, 256, 1);
        do_write(7, 32767, 32767, 32767, 256, 1);
        expect_direct(1, 0, 1280, 8'h01, 1);
        run_ray("overflow", 0, 0, 256, 0, 0, 0, 0, 0, 0);

`ifdef SPHERE_SCAN_ORIGIN_EN
        clear_table();
        do_write(0, 0, 0, 1280, 256, 1);
        expect_direct(1, 0, 768, 8'h01, 0);
        run_ray("origin", 0, 0, 256, 0, 0, 512, 0, 0, 0);
`endif

        // reset in the middle of a scan
        do_write(3, 0, 0, 1024, 256, 1);
        @(negedge clk);
        ray = pack3(0, 0, 256);
        ray_valid = 1;
        @(posedge clk); #1;
        ray_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < N; i++) m_v[i] = 0;
        @(negedge clk);
        chk_eq("midrst_res_valid", res_valid, 0);
        chk_eq("midrst_ray_ready", ray_ready, 1);
        chk_eq("midrst_hit_mask", hit_mask, 0);
        repeat (N + 4) @(negedge clk);
        chk_eq("midrst_res_valid_later", res_valid, 0);
        expect_direct(0, 0, 0, 8'h00, 0);
        run_ray("midrst_empty", 0, 0, 256, 0, 0, 0, 0, 0, 0);

        // randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                do_write(int'($urandom_range(0, N - 1)), rand_comp(), rand_comp(), rand_comp(),
                         int'($urandom_range(0, 1024)), $urandom_range(0, 3) != 0);
            end
            pw_idx = int'($urandom_range(0, N - 1));
            pw_c = '{rand_comp(), rand_comp(), rand_comp()};
            pw_r = int'($urandom_range(0, 1024));
            pw_v = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 1) == 0) begin
                int ax;
                ax = int'($urandom_range(0, 2));
                run_ray("rand", (ax == 0) ? 256 : 0, (ax == 1) ? 256 : 0, (ax == 2) ? -256 : 0,
                        rand_dir(), rand_dir(), rand_dir(),
                        int'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                        $urandom_range(0, 3) == 0);
            end else begin
                run_ray("rand", rand_dir(), rand_dir(), rand_dir(),
                        rand_dir(), rand_dir(), rand_dir(),
                        int'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                        $urandom_range(0, 3) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
